fftmag_writer: RTL

//  Upstream stage of freqdetect. Accepts one FFT frame as a streaming complex

---
 rtl/fftmag_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fftmag_writer.sv
`timescale 1ns/1ps
// fftmag_writer
//   Takes one FFT frame as a stream of complex bins, squares and sums each
//   bin (re^2 + im^2) and writes the result to the bin RAM at address k for
//   bin k. When a full frame has landed in RAM it pulses fftdone and holds
//   the FFT source off (src_ready low) until detectdone releases the RAM.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   src_valid         FFT sample valid
//   src_sop/src_eop   first/last bin of frame, qualified by src_valid
//   src_real/imag     signed DW-bit sample
//   src_ready         sample accepted this cycle when high with src_valid
//   detectdone        downstream scan finished, RAM may be overwritten
//   ramwraddr/ramdata/ramwren   RAM write port (squared magnitude)
//   fftdone           one-cycle pulse: full frame in RAM
//   frameerr          sticky malformed-frame flag, cleared by reset only
module fftmag_writer #(
  parameter int NPOINTS = 1024,
  parameter int DW      = 14,
  parameter int AW      = 11,
  parameter int MW      = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_valid,
  input  logic                 src_sop,
  input  logic                 src_eop,
  input  logic signed [DW-1:0] src_real,
  input  logic signed [DW-1:0] src_imag,
  output logic                 src_ready,
  input  logic                 detectdone,
  output logic [AW-1:0]        ramwraddr,
  output logic [MW-1:0]        ramdata,
  output logic                 ramwren,
  output logic                 fftdone,
  output logic                 frameerr
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    HOLD
  } state_t;

  localparam logic [AW-1:0] LAST_BIN = AW'(NPOINTS - 1);
  localparam int            SQW      = 2 * DW - 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_bin;
  logic [AW-1:0]   w_bin_nxt;
  logic [AW-1:0]   w_idx;
  logic            w_xfer;
  logic            w_write;
  logic            w_err;
  logic            w_done_nxt;
  logic            w_ready_nxt;

  logic            r_v1;
  logic [AW-1:0]   r_addr1;
  logic [SQW-1:0]  r_re2;
  logic [SQW-1:0]  r_im2;

  logic [DW-1:0]   w_re_abs;
  logic [DW-1:0]   w_im_abs;
  logic [SQW-1:0]  w_re_sq;
  logic [SQW-1:0]  w_im_sq;

  // Squaring the magnitude gives the same result as the signed square. The
  // most negative input still fits as an unsigned DW-bit magnitude, and the
  // square is at most 2^(2DW-2), so SQW bits hold it exactly.
  always_comb begin
    w_re_abs = src_real[DW-1] ? DW'(-src_real) : DW'(src_real);
    w_im_abs = src_imag[DW-1] ? DW'(-src_imag) : DW'(src_imag);
    w_re_sq  = SQW'(w_re_abs) * SQW'(w_re_abs);
    w_im_sq  = SQW'(w_im_abs) * SQW'(w_im_abs);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_write     = 1'b0;
    w_err       = 1'b0;
    w_done_nxt  = 1'b0;
    w_xfer      = src_valid && src_ready;
    // sop always restarts numbering, so a mid-frame sop lands on bin 0
    w_idx       = src_sop ? '0 : r_bin;

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (src_sop) w_write = 1'b1;
          else         w_err   = 1'b1;
        end
      end
      FILL: begin
        if (w_xfer) begin
          w_write = 1'b1;
          if (src_sop) w_err = 1'b1;
        end
      end
      FLUSH: begin
        // Final bin sits in stage 1 on the first FLUSH cycle; once stage 1
        // is empty and stage 2 is writing, that write is the last one.
        if (!r_v1 && ramwren) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (detectdone) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_write) begin
      w_bin_nxt = w_idx + AW'(1);
      if (w_idx == LAST_BIN) begin
        w_state_nxt = FLUSH;
        if (!src_eop) w_err = 1'b1;
      end else if (src_eop) begin
        w_state_nxt = IDLE;
        w_err       = 1'b1;
      end else begin
        w_state_nxt = FILL;
      end
    end

    w_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      src_ready <= 1'b0;
      fftdone   <= 1'b0;
      frameerr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      src_ready <= w_ready_nxt;
      fftdone   <= w_done_nxt;
      frameerr  <= frameerr | w_err;
    end
  end

  // Pipeline is not cleared on frame abort: accepted samples are written.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_addr1   <= '0;
      r_re2     <= '0;
      r_im2     <= '0;
      ramwren   <= 1'b0;
      ramwraddr <= '0;
      ramdata   <= '0;
    end else begin
      r_v1    <= w_write;
      ramwren <= r_v1;
      if (w_write) begin
        r_addr1 <= w_idx;
        r_re2   <= w_re_sq;
        r_im2   <= w_im_sq;
      end
      if (r_v1) begin
        ramwraddr <= r_addr1;
        ramdata   <= MW'(r_re2) + MW'(r_im2);
      end
    end
  end

endmodule
